// File: rtl/control_unit_gen.sv
// Fetch/decode/execute control unit with an NREG-entry register file, full NZVC branches
// and illegal-opcode detection. Define CU_MEM_WAIT_EN to hold memory states until mem_ready.
module control_unit_gen #(
    parameter int NREG = 4
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic [7:0]      IR,
    input  logic [3:0]      CCR_Result,
    input  logic            mem_ready,
    output logic            IR_Load,
    output logic            MAR_Load,
    output logic            PC_Load,
    output logic            PC_Inc,
    output logic            CCR_Load,
    output logic            write,
    output logic [NREG-1:0] Reg_Load,
    output logic [1:0]      Rsel_A,
    output logic [1:0]      Rsel_B,
    output logic [2:0]      ALU_Sel,
    output logic [1:0]      Bus1_Sel,
    output logic [1:0]      Bus2_Sel,
    output logic            illegal,
    output logic [4:0]      current_state
);

    // state | meaning
    // 00-03 | FETCH0..2 (PC->MAR, PC_Inc, mem->IR), DECODE
    // 04-06 | IMM0..2   07-0B | DIR0..4 (0A = read wait)   0C | ST write
    // 0D    | ALU       0E-0F | BR0, BR1 (condition)       10/11 | BR_TAKE/BR_SKIP
    typedef enum logic [4:0] {
        FETCH0  = 5'h00, FETCH1 = 5'h01, FETCH2 = 5'h02, DECODE = 5'h03,
        IMM0    = 5'h04, IMM1   = 5'h05, IMM2   = 5'h06,
        DIR0    = 5'h07, DIR1   = 5'h08, DIR2   = 5'h09, DIR3 = 5'h0A, DIR4 = 5'h0B,
        ST      = 5'h0C, ALU_EX = 5'h0D, BR0    = 5'h0E, BR1  = 5'h0F,
        BR_TAKE = 5'h10, BR_SKIP = 5'h11
    } state_t;

    state_t     state;
    logic       ready;
    logic       is_nop, is_imm, is_ld_dir, is_st, is_alu, is_br, legal;
    logic       taken;
    logic       reg_we;
    logic [1:0] dest;

`ifdef CU_MEM_WAIT_EN
    assign ready = mem_ready;
`else
    logic unused_mem_ready;
    assign ready            = 1'b1;
    assign unused_mem_ready = mem_ready;
`endif

    function automatic logic idx_ok(input logic [1:0] idx);
        return int'(idx) < NREG;
    endfunction

    always_comb begin
        is_nop    = (IR == 8'h00);
        is_imm    = (IR[7:4] == 4'h8) && idx_ok(IR[1:0]);
        is_ld_dir = (IR[7:4] == 4'h9) && idx_ok(IR[1:0]);
        is_st     = (IR[7:4] == 4'hA) && idx_ok(IR[1:0]);
        is_alu    = (IR[7:6] == 2'b01) && idx_ok(IR[3:2]) && idx_ok(IR[1:0]);
        is_br     = (IR[7:4] == 4'h2) && (IR[3:0] <= 4'd8);
        legal     = is_nop | is_imm | is_ld_dir | is_st | is_alu | is_br;
    end

    // CCR_Result = {N,Z,V,C}
    always_comb begin
        case (IR[3:0])
            4'd0:    taken = 1'b1;
            4'd1:    taken = CCR_Result[3];
            4'd2:    taken = ~CCR_Result[3];
            4'd3:    taken = CCR_Result[2];
            4'd4:    taken = ~CCR_Result[2];
            4'd5:    taken = CCR_Result[1];
            4'd6:    taken = ~CCR_Result[1];
            4'd7:    taken = CCR_Result[0];
            4'd8:    taken = ~CCR_Result[0];
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= FETCH0;
        end else begin
            case (state)
                FETCH0:  state <= FETCH1;
                FETCH1:  if (ready) state <= FETCH2;
                FETCH2:  state <= DECODE;
                DECODE: begin
                    if (is_imm)                  state <= IMM0;
                    else if (is_ld_dir || is_st) state <= DIR0;
                    else if (is_alu)             state <= ALU_EX;
                    else if (is_br)              state <= BR0;
                    else                         state <= FETCH0;
                end
                IMM0:    state <= IMM1;
                IMM1:    if (ready) state <= IMM2;
                IMM2:    state <= FETCH0;
                DIR0:    state <= DIR1;
                DIR1:    if (ready) state <= DIR2;
                DIR2:    state <= is_st ? ST : DIR3;
                DIR3:    if (ready) state <= DIR4;
                DIR4:    state <= FETCH0;
                ST:      if (ready) state <= FETCH0;
                ALU_EX:  state <= FETCH0;
                BR0:     state <= BR1;
                BR1:     if (ready) state <= taken ? BR_TAKE : BR_SKIP;
                BR_TAKE: state <= FETCH0;
                BR_SKIP: state <= FETCH0;
                default: state <= FETCH0;
            endcase
        end
    end

    // Outputs decode the registered state; Reset forces every output low.
    always_comb begin
        IR_Load       = 1'b0;
        MAR_Load      = 1'b0;
        PC_Load       = 1'b0;
        PC_Inc        = 1'b0;
        CCR_Load      = 1'b0;
        write         = 1'b0;
        Reg_Load      = '0;
        Rsel_A        = 2'b00;
        Rsel_B        = 2'b00;
        ALU_Sel       = 3'b000;
        Bus1_Sel      = 2'b00;
        Bus2_Sel      = 2'b00;
        illegal       = 1'b0;
        current_state = 5'h00;
        reg_we        = 1'b0;
        dest          = IR[1:0];
        if (!Reset) begin
            current_state = state;
            case (state)
                FETCH0, IMM0, DIR0, BR0: begin
                    Bus1_Sel = 2'b00;
                    Bus2_Sel = 2'b01;
                    MAR_Load = 1'b1;
                end
                FETCH1, IMM1, DIR1: PC_Inc = ready;
                FETCH2: begin
                    Bus2_Sel = 2'b10;
                    IR_Load  = 1'b1;
                end
                DECODE: illegal = ~legal;
                IMM2, DIR4: begin
                    Bus2_Sel = 2'b10;
                    reg_we   = 1'b1;
                end
                DIR2: begin
                    Bus2_Sel = 2'b10;
                    MAR_Load = 1'b1;
                end
                ST: begin
                    Bus1_Sel = 2'b01;
                    Rsel_A   = IR[1:0];
                    Bus2_Sel = 2'b01;
                    write    = 1'b1;
                end
                ALU_EX: begin
                    Rsel_A   = IR[3:2];
                    Rsel_B   = IR[1:0];
                    ALU_Sel  = {1'b0, IR[5:4]};
                    Bus2_Sel = 2'b00;
                    CCR_Load = 1'b1;
                    reg_we   = 1'b1;
                    dest     = IR[3:2];
                end
                BR_TAKE: begin
                    Bus2_Sel = 2'b10;
                    PC_Load  = 1'b1;
                end
                BR_SKIP: PC_Inc = 1'b1;
                default: ;
            endcase
            for (int i = 0; i < NREG; i++) begin
                if (reg_we && dest == 2'(i)) Reg_Load[i] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_control_unit_gen.sv
// Scoreboard bench for control_unit_gen: directed instructions push per-cycle expected
// output bundles; a negedge monitor pops and compares. NREG=4 main instance, NREG=2 second.
module tb_control_unit_gen;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] IR = 8'h00;
    logic [3:0] CCR_Result = 4'h0;
    logic       mem_ready;

    logic       ir_ld1, mar1, pcld1, pcinc1, ccr1, wr1, ill1;
    logic [3:0] rl1;
    logic [1:0] ra1, rb1, b11, b21;
    logic [2:0] alu1;
    logic [4:0] cs1;

    logic       ir_ld2, mar2, pcld2, pcinc2, ccr2, wr2, ill2;
    logic [1:0] rl2;
    logic [1:0] ra2, rb2, b12, b22;
    logic [2:0] alu2;
    logic [4:0] cs2;

    always #5 Clk = ~Clk;

    control_unit_gen #(.NREG(4)) dut (
        .Clk(Clk), .Reset(Reset), .IR(IR), .CCR_Result(CCR_Result), .mem_ready(mem_ready),
        .IR_Load(ir_ld1), .MAR_Load(mar1), .PC_Load(pcld1), .PC_Inc(pcinc1),
        .CCR_Load(ccr1), .write(wr1), .Reg_Load(rl1), .Rsel_A(ra1), .Rsel_B(rb1),
        .ALU_Sel(alu1), .Bus1_Sel(b11), .Bus2_Sel(b21), .illegal(ill1), .current_state(cs1)
    );

    control_unit_gen #(.NREG(2)) dut2 (
        .Clk(Clk), .Reset(Reset), .IR(IR), .CCR_Result(CCR_Result), .mem_ready(mem_ready),
        .IR_Load(ir_ld2), .MAR_Load(mar2), .PC_Load(pcld2), .PC_Inc(pcinc2),
        .CCR_Load(ccr2), .write(wr2), .Reg_Load(rl2), .Rsel_A(ra2), .Rsel_B(rb2),
        .ALU_Sel(alu2), .Bus1_Sel(b12), .Bus2_Sel(b22), .illegal(ill2), .current_state(cs2)
    );

    typedef struct packed {
        logic [4:0] st;
        logic       ir_ld, mar_ld, pc_ld, pc_inc, ccr_ld, wr;
        logic [3:0] reg_ld;
        logic [1:0] rsa, rsb;
        logic [2:0] alu;
        logic [1:0] b1, b2;
        logic       ill;
    } obs_t;

    localparam logic [5:0] S_NONE = 6'b000000, S_IR = 6'b100000, S_MAR = 6'b010000;
    localparam logic [5:0] S_PCLD = 6'b001000, S_INC = 6'b000100, S_CCR = 6'b000010;
    localparam logic [5:0] S_WR = 6'b000001;
    localparam logic [1:0] B1_PC = 2'b00, B1_REG = 2'b01;
    localparam logic [1:0] B2_ALU = 2'b00, B2_B1 = 2'b01, B2_MEM = 2'b10;

    obs_t obs1, obs2;
    assign obs1 = {cs1, ir_ld1, mar1, pcld1, pcinc1, ccr1, wr1, rl1, ra1, rb1, alu1, b11, b21, ill1};
    assign obs2 = {cs2, ir_ld2, mar2, pcld2, pcinc2, ccr2, wr2, {2'b00, rl2}, ra2, rb2, alu2, b12, b22, ill2};

    obs_t q1[$];
    obs_t q2[$];
    int   n_tests = 0;
    int   n_fail = 0;

    function automatic obs_t mk(input logic [4:0] st, input logic [5:0] s, input logic [3:0] rl,
                                input logic [1:0] ra, input logic [1:0] rb, input logic [2:0] alu,
                                input logic [1:0] b1, input logic [1:0] b2, input logic ill);
        obs_t o;
        o.st = st;
        {o.ir_ld, o.mar_ld, o.pc_ld, o.pc_inc, o.ccr_ld, o.wr} = s;
        o.reg_ld = rl;
        o.rsa = ra;
        o.rsb = rb;
        o.alu = alu;
        o.b1 = b1;
        o.b2 = b2;
        o.ill = ill;
        return o;
    endfunction

    function automatic obs_t st_only(input logic [4:0] st);
        return mk(st, S_NONE, 4'h0, 2'd0, 2'd0, 3'd0, B1_PC, B2_ALU, 1'b0);
    endfunction

    function automatic obs_t pc_to_mar(input logic [4:0] st);
        return mk(st, S_MAR, 4'h0, 2'd0, 2'd0, 3'd0, B1_PC, B2_B1, 1'b0);
    endfunction

    function automatic obs_t pc_inc(input logic [4:0] st);
        return mk(st, S_INC, 4'h0, 2'd0, 2'd0, 3'd0, B1_PC, B2_ALU, 1'b0);
    endfunction

    // Monitor: one expected bundle per cycle while the queue holds entries.
    always @(negedge Clk) begin
        obs_t e;
        if (q1.size() > 0) begin
            e = q1.pop_front();
            n_tests++;
            if (obs1 !== e) begin
                n_fail++;
                $display("FAIL nreg4 t=%0t: state %h bundle %h, expected state %h bundle %h",
                         $time, obs1.st, obs1, e.st, e);
            end
        end
        if (q2.size() > 0) begin
            e = q2.pop_front();
            n_tests++;
            if (obs2 !== e) begin
                n_fail++;
                $display("FAIL nreg2 t=%0t: state %h bundle %h, expected state %h bundle %h",
                         $time, obs2.st, obs2, e.st, e);
            end
        end
    end

    task automatic push_fetch(input logic ill);
        q1.push_back(pc_to_mar(5'h00));
        q1.push_back(pc_inc(5'h01));
        q1.push_back(mk(5'h02, S_IR, 4'h0, 2'd0, 2'd0, 3'd0, B1_PC, B2_MEM, 1'b0));
        q1.push_back(mk(5'h03, S_NONE, 4'h0, 2'd0, 2'd0, 3'd0, B1_PC, B2_ALU, ill));
    endtask

    // Returns one cycle after the last expected entry was checked, i.e. in the next FETCH0.
    task automatic drain();
        int n = 0;
        while ((q1.size() > 0 || q2.size() > 0) && n < 100) begin
            @(posedge Clk);
            n++;
        end
        if (q1.size() > 0 || q2.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d entries left, required 0", q1.size() + q2.size());
            q1.delete();
            q2.delete();
        end
        #1;
    endtask

    task automatic run_illegal(input logic [7:0] ir, input logic ill);
        IR = ir;
        push_fetch(ill);
        drain();
    endtask

    task automatic run_alu(input logic [7:0] ir, input logic [3:0] rl, input logic [1:0] ra,
                           input logic [1:0] rb, input logic [2:0] alu);
        IR = ir;
        push_fetch(1'b0);
        q1.push_back(mk(5'h0D, S_CCR, rl, ra, rb, alu, B1_PC, B2_ALU, 1'b0));
        drain();
    endtask

    task automatic run_imm(input logic [7:0] ir, input logic [3:0] rl);
        IR = ir;
        push_fetch(1'b0);
        q1.push_back(pc_to_mar(5'h04));
        q1.push_back(pc_inc(5'h05));
        q1.push_back(mk(5'h06, S_NONE, rl, 2'd0, 2'd0, 3'd0, B1_PC, B2_MEM, 1'b0));
        drain();
    endtask

    task automatic run_lddir(input logic [7:0] ir, input logic [3:0] rl);
        IR = ir;
        push_fetch(1'b0);
        q1.push_back(pc_to_mar(5'h07));
        q1.push_back(pc_inc(5'h08));
        q1.push_back(mk(5'h09, S_MAR, 4'h0, 2'd0, 2'd0, 3'd0, B1_PC, B2_MEM, 1'b0));
        q1.push_back(st_only(5'h0A));
        q1.push_back(mk(5'h0B, S_NONE, rl, 2'd0, 2'd0, 3'd0, B1_PC, B2_MEM, 1'b0));
        drain();
    endtask

    task automatic push_st_prefix();
        push_fetch(1'b0);
        q1.push_back(pc_to_mar(5'h07));
        q1.push_back(pc_inc(5'h08));
        q1.push_back(mk(5'h09, S_MAR, 4'h0, 2'd0, 2'd0, 3'd0, B1_PC, B2_MEM, 1'b0));
    endtask

    task automatic run_st(input logic [7:0] ir, input logic [1:0] rs);
        IR = ir;
        push_st_prefix();
        q1.push_back(mk(5'h0C, S_WR, 4'h0, rs, 2'd0, 3'd0, B1_REG, B2_B1, 1'b0));
        drain();
    endtask

    task automatic run_br(input logic [7:0] ir, input logic [3:0] ccr, input logic tk);
        IR = ir;
        CCR_Result = ccr;
        push_fetch(1'b0);
        q1.push_back(pc_to_mar(5'h0E));
        q1.push_back(st_only(5'h0F));
        if (tk) q1.push_back(mk(5'h10, S_PCLD, 4'h0, 2'd0, 2'd0, 3'd0, B1_PC, B2_MEM, 1'b0));
        else    q1.push_back(pc_inc(5'h11));
        drain();
    endtask

    initial begin
`ifdef CU_MEM_WAIT_EN
        mem_ready = 1'b1;
`else
        mem_ready = 1'b0;   // ignored in this build; any dependence shows up as a stall
`endif
        q1.push_back('0);   // while Reset is high every output reads 0
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;

        run_illegal(8'h00, 1'b0);

        // ADD r2,r3: legal with four registers, illegal with two
        IR = 8'h4B;
        push_fetch(1'b0);
        q1.push_back(mk(5'h0D, S_CCR, 4'b0100, 2'd2, 2'd3, 3'b000, B1_PC, B2_ALU, 1'b0));
        q2.push_back(pc_to_mar(5'h00));
        q2.push_back(pc_inc(5'h01));
        q2.push_back(mk(5'h02, S_IR, 4'h0, 2'd0, 2'd0, 3'd0, B1_PC, B2_MEM, 1'b0));
        q2.push_back(mk(5'h03, S_NONE, 4'h0, 2'd0, 2'd0, 3'd0, B1_PC, B2_ALU, 1'b1));
        q2.push_back(pc_to_mar(5'h00));
        drain();

        // Reset during DIR2 of LD_DIR: abandon, FETCH0 one edge later
        IR = 8'h92;
        push_fetch(1'b0);
        q1.push_back(pc_to_mar(5'h07));
        q1.push_back(pc_inc(5'h08));
        q1.push_back('0);
        repeat (6) @(posedge Clk);
        #1;
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        Reset = 1'b0;

        run_st(8'hA1, 2'd1);
        run_br(8'h23, 4'b0100, 1'b1);
        run_br(8'h23, 4'b0000, 1'b0);
        run_br(8'h28, 4'b1110, 1'b1);
        run_br(8'h28, 4'b0001, 1'b0);
        run_br(8'h21, 4'b1000, 1'b1);
        run_br(8'h26, 4'b0010, 1'b0);
        run_br(8'h20, 4'b0000, 1'b1);
        run_illegal(8'h2C, 1'b1);
        run_illegal(8'hFF, 1'b1);
        run_illegal(8'h29, 1'b1);
        run_illegal(8'h01, 1'b1);
        run_imm(8'h85, 4'b0010);
        run_lddir(8'h93, 4'b1000);
        run_alu(8'h5D, 4'b1000, 2'd3, 2'd1, 3'b001);
        run_alu(8'h70, 4'b0001, 2'd0, 2'd0, 3'b011);
        run_alu(8'h66, 4'b0010, 2'd1, 2'd2, 3'b010);

`ifdef CU_MEM_WAIT_EN
        // FETCH1 held three cycles, PC_Inc only in the exit cycle
        IR = 8'h00;
        mem_ready = 1'b0;
        q1.push_back(pc_to_mar(5'h00));
        repeat (3) q1.push_back(st_only(5'h01));
        q1.push_back(pc_inc(5'h01));
        q1.push_back(mk(5'h02, S_IR, 4'h0, 2'd0, 2'd0, 3'd0, B1_PC, B2_MEM, 1'b0));
        q1.push_back(st_only(5'h03));
        repeat (4) @(posedge Clk);
        #1;
        mem_ready = 1'b1;
        drain();

        // ST held in 0C: write every held cycle
        IR = 8'hA2;
        push_st_prefix();
        repeat (3) q1.push_back(mk(5'h0C, S_WR, 4'h0, 2'd2, 2'd0, 3'd0, B1_REG, B2_B1, 1'b0));
        repeat (7) @(posedge Clk);
        #1;
        mem_ready = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        mem_ready = 1'b1;
        drain();

        // BR1 held: condition taken from CCR in the exit cycle only
        IR = 8'h23;
        CCR_Result = 4'b0000;
        push_fetch(1'b0);
        q1.push_back(pc_to_mar(5'h0E));
        repeat (2) q1.push_back(st_only(5'h0F));
        q1.push_back(mk(5'h10, S_PCLD, 4'h0, 2'd0, 2'd0, 3'd0, B1_PC, B2_MEM, 1'b0));
        repeat (5) @(posedge Clk);
        #1;
        mem_ready = 1'b0;
        @(posedge Clk);
        #1;
        mem_ready = 1'b1;
        CCR_Result = 4'b0100;
        drain();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/control_unit_gen.md
# control_unit_gen

Parametrised successor to the 8-bit computer control unit. It is a fetch/decode/execute FSM that drives the datapath load, select and write strobes. Compared with the fixed two-register version it adds:
- an NREG-entry register file addressed by opcode fields;
- the full NZVC branch set;
- illegal-opcode detection;
- an optional memory wait handshake.

It sits between the IR/CCR of the datapath and the memory/register strobes.

## Interface
- NREG, 4, number of general registers, legal range 2..4; register index fields are always 2 bits.
- Clk  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high; forces state 00h and all outputs to 0 while high
- IR  in  8  instruction register contents
- CCR_Result  in  4  flags {N,Z,V,C} = bits [3:0]
- mem_ready  in  1  memory access complete (used only with CU_MEM_WAIT_EN)
- IR_Load, MAR_Load, PC_Load, PC_Inc, CCR_Load, write  out  1 each  datapath strobes
- Reg_Load  out  NREG  one-hot register load
- Rsel_A, Rsel_B  out  2 each  register-file read ports (ALU A/B; Rsel_A also feeds Bus1)
- ALU_Sel  out  3  000 ADD, 001 SUB, 010 AND, 011 OR
- Bus1_Sel  out  2  00 PC, 01 register[Rsel_A]
- Bus2_Sel  out  2  00 ALU, 01 Bus1, 10 memory
- illegal  out  1  one-cycle pulse in DECODE for an undefined opcode
- current_state  out  5  state code (debug/verification)

## Operation
- Opcode classes, using IR[7:4]; rd = IR[3:2], rs = IR[1:0]:
  - 00h: NOP.
  - 8xh: LD_IMM, rd = IR[1:0].
  - 9xh: LD_DIR, rd = IR[1:0].
  - Axh: ST_DIR, rs = IR[1:0].
  - 4x/5x/6x/7x: ADD/SUB/AND/OR, rd ← rd op rs.
  - 2xh: branch, cond = IR[3:0]. 0 BRA, 1 BMI (N), 2 BPL (!N), 3 BEQ (Z), 4 BNE (!Z), 5 BVS (V), 6 BVC (!V), 7 BCS (C), 8 BCC (!C).
- Illegal opcodes:
  - Any other opcode, a branch cond > 8, or any register index ≥ NREG.
  - The unit pulses illegal in DECODE and returns to FETCH0.
  - No other strobe is asserted.
- States and outputs (all strobes not listed are 0):
  - 00 FETCH0: Bus1_Sel=PC, Bus2_Sel=Bus1, MAR_Load.
  - 01 FETCH1: PC_Inc.
  - 02 FETCH2: Bus2_Sel=mem, IR_Load.
  - 03 DECODE: no strobes.
  - 04 IMM0: PC→MAR. 05 IMM1: PC_Inc. 06 IMM2: Bus2_Sel=mem, Reg_Load[rd].
  - 07 DIR0: PC→MAR. 08 DIR1: PC_Inc. 09 DIR2: Bus2_Sel=mem, MAR_Load.
  - 0A DIR3: read wait. 0B DIR4: Bus2_Sel=mem, Reg_Load[rd].
  - 0C ST: Bus1_Sel=reg, Rsel_A=rs, Bus2_Sel=Bus1, write.
  - 0D ALU: Rsel_A=rd, Rsel_B=rs, ALU_Sel, Bus2_Sel=ALU, Reg_Load[rd], CCR_Load.
  - 0E BR0: PC→MAR.
  - 0F BR1: branch condition evaluated from CCR_Result this cycle.
  - 10 BR_TAKE: Bus2_Sel=mem, PC_Load.
  - 11 BR_SKIP: PC_Inc (skips the offset byte).
- Transitions:
  - Fetch sequence: 00→01→02→03.
  - Decode targets: NOP/illegal→00, LD_IMM→04, LD_DIR/ST_DIR→07, ALU→0D, branch→0E.
  - LD_IMM: 04→05→06→00.
  - LD_DIR: 07→08→09→0A→0B→00.
  - ST_DIR: 07→08→09→0C→00.
  - ALU: 0D→00.
  - Branch: 0E→0F→(10 if taken, else 11)→00.
- Unused state codes go to 00 on the next clock.

## Timing
- Outputs are combinational decodes of the registered state, plus IR and mem_ready where noted.
- State registers on the rising edge of Clk.
- Latency in cycles, FETCH0 through the last state inclusive, zero wait:
  - NOP/illegal: 4.
  - ALU: 5.
  - LD_IMM and branch: 7.
  - ST_DIR: 8.
  - LD_DIR: 9.
- Reset high on any edge gives state 00 on the next cycle, with all outputs 0 while Reset=1. Mid-instruction reset abandons the instruction; no partial write or load completes after that edge.
- IR must be stable from FETCH2+1 until the instruction returns to 00.
- CCR_Result is sampled only in BR1.

## Configuration
- CU_MEM_WAIT_EN defined:
  - Wait states 01, 05, 08, 0A, 0F and 0C hold until mem_ready=1. Exit occurs on the edge where mem_ready=1 is sampled.
  - PC_Inc in 01/05/08 is asserted only in the exit cycle (mem_ready=1), so it is one pulse per access.
  - write in 0C is asserted every held cycle.
  - In BR1 the condition is evaluated in the exit cycle.
- CU_MEM_WAIT_EN undefined: mem_ready is ignored, and every state lasts exactly one cycle.

## Test plan
- Reset:
  - Drive Reset=1 mid-LD_DIR, in state 09.
  - Required: current_state=00 after one edge; all outputs 0 while Reset is high; no Reg_Load asserted.
- ALU:
  - IR=4Bh (ADD, rd=2, rs=3), NREG=4.
  - Required: state 0D with Rsel_A=2, Rsel_B=3, ALU_Sel=000, Reg_Load=0100, CCR_Load=1; then 00.
  - Same opcode with NREG=2: illegal pulses in 03, next state 00.
- Store:
  - IR=A1h.
  - Required: state sequence 00,01,02,03,07,08,09,0C; in 0C write=1, Bus1_Sel=01, Rsel_A=1.
- Branch:
  - BEQ (23h) with CCR_Result=0100: 0F→10 with PC_Load=1.
  - BEQ with CCR_Result=0000: 0F→11, PC_Inc=1, PC_Load never asserted.
  - BCC (28h) with C=0: taken.
- Undefined opcodes:
  - IR=2Ch or FFh.
  - Required: illegal=1 for exactly one cycle in 03; no strobes; next state 00.
- Wait handshake (CU_MEM_WAIT_EN):
  - Hold mem_ready=0 for 3 cycles in FETCH1.
  - Required: state stays 01 for 4 cycles; PC_Inc=1 only in the cycle with mem_ready=1.
  - ST_DIR: write stays 1 for all held cycles.
